// File: rtl/div_unit.sv
// div_unit -- multicycle signed 32-bit integer divider for the DIV instruction.
//
// A start command latches operand magnitudes and runs a 32-iteration restoring
// division. The result is then sign-corrected: the quotient truncates toward
// zero and the remainder takes the sign of the dividend.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous reset, active-low
//   divControl  in   2'b00 no-op, 2'b01 start DIV, 2'b10 abort, 2'b11 DIVU/no-op
//   a, b        in   dividend / divisor, sampled on the accepted start edge
//   hi          out  remainder; holds between operations
//   lo          out  quotient; holds between operations
//   busy        out  high while an operation is in flight
//   done        out  one-cycle pulse, hi/lo valid
//   div0        out  one-cycle pulse, start was issued with a zero divisor
//
// Build option: define DIV_UNIT_DIVU_EN to make 2'b11 start an unsigned DIVU.
// Without it, 2'b11 is a no-op in every state.

module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  divControl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, stateNext;
    logic [32:0] rem;
    logic [31:0] quot;
    logic [31:0] divisor;
    logic [4:0]  cnt;
    logic        signQ, signR;

    logic        isStart, isUnsigned, isAbort;
    logic [31:0] magA, magB;
    logic [32:0] shifted;
    logic [33:0] trial;

`ifdef DIV_UNIT_DIVU_EN
    assign isStart    = (divControl == 2'b01) || (divControl == 2'b11);
    assign isUnsigned = (divControl == 2'b11);
`else
    assign isStart    = (divControl == 2'b01);
    assign isUnsigned = 1'b0;
`endif
    assign isAbort = (divControl == 2'b10);

    // Magnitudes wrap in 32-bit unsigned arithmetic, so |0x80000000| stays 0x80000000.
    always_comb begin
        magA = (isUnsigned || !a[31]) ? a : -a;
        magB = (isUnsigned || !b[31]) ? b : -b;
    end

    // One restoring step; trial is one bit wider than rem so its MSB is a clean borrow.
    always_comb begin
        shifted = {rem[31:0], quot[31]};
        trial   = {1'b0, shifted} - {2'b00, divisor};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (isStart && (b != '0)) begin
                    stateNext = CALC;
                end
            end
            CALC: begin
                if (isAbort) begin
                    stateNext = IDLE;
                end else if (cnt == 5'd31) begin
                    stateNext = FIX;
                end
            end
            FIX: begin
                if (isAbort) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (stateNext != IDLE);
            done <= (stateNext == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            cnt     <= '0;
            signQ   <= 1'b0;
            signR   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            div0    <= 1'b0;
        end else begin
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (isStart) begin
                        if (b == '0) begin
                            div0 <= 1'b1;
                        end else begin
                            quot    <= magA;
                            divisor <= magB;
                            rem     <= '0;
                            cnt     <= '0;
                            signQ   <= !isUnsigned && (a[31] ^ b[31]);
                            signR   <= !isUnsigned && a[31];
                        end
                    end
                end
                CALC: begin
                    if (!isAbort) begin
                        if (!trial[33]) begin
                            rem  <= trial[32:0];
                            quot <= {quot[30:0], 1'b1};
                        end else begin
                            rem  <= shifted;
                            quot <= {quot[30:0], 1'b0};
                        end
                        cnt <= cnt + 5'd1;
                    end
                end
                FIX: begin
                    if (!isAbort) begin
                        lo <= signQ ? -quot : quot;
                        hi <= signR ? -rem[31:0] : rem[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
